// File: rtl/onoff_pkg.sv
// Shared types for the on/off dwell tracker.
// Record layout and FSM state encoding.
package onoff_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_OFF = 1'b0,
    S_ON  = 1'b1
  } state_t;

  typedef struct packed {
    logic             sat;
    logic [CNT_W-1:0] len;
  } len_rec_t;

endpackage

// File: rtl/onoff_len_outreg.sv
// Single-entry valid/ready holding register for ON-length records.
// A record arriving while the slot is held and not draining is dropped.
module onoff_len_outreg #(
  parameter int CNT_W  = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              emit,
  input  logic [CNT_W-1:0]  emit_len,
  input  logic              emit_sat,
  output logic              len_valid,
  input  logic              len_ready,
  output logic [CNT_W-1:0]  len_data,
  output logic              len_sat,
  output logic [DROP_W-1:0] drop_cnt
);

  import onoff_pkg::*;

  logic fire;
  logic load;
  logic drop;
  logic drain;

  assign fire  = len_valid & len_ready;
  assign load  = emit & (~len_valid | fire);
  assign drop  = emit & len_valid & ~fire;
  assign drain = ~emit & fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      len_valid <= 1'b0;
      len_data  <= '0;
      len_sat   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      unique case (1'b1)
        load: begin
          len_valid <= 1'b1;
          len_data  <= emit_len;
          len_sat   <= emit_sat;
        end
        drop: begin
          if (drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
        end
        drain: begin
          len_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/onoff_dwell_tracker.sv
// Tracks ON/OFF dwell of an upstream level, strobes edges,
// and reports each ON interval length through a valid/ready slot.
module onoff_dwell_tracker #(
  parameter int CNT_W  = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic              rise,
  output logic              fall,
  output logic              on_state,
  output logic              len_valid,
  input  logic              len_ready,
  output logic [CNT_W-1:0]  len_data,
  output logic              len_sat,
  output logic [DROP_W-1:0] drop_cnt
);

  import onoff_pkg::*;

  localparam logic [CNT_W-1:0] LEN_MAX = '1;
  localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] len_cnt;
  logic [CNT_W-1:0] len_cnt_nx;
  logic             sat;
  logic             sat_nx;
  logic             rise_nx;
  logic             fall_nx;
  logic             emit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_OFF;
      len_cnt <= '0;
      sat     <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state   <= state_nx;
      len_cnt <= len_cnt_nx;
      sat     <= sat_nx;
      rise    <= rise_nx;
      fall    <= fall_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    len_cnt_nx = len_cnt;
    sat_nx     = sat;
    rise_nx    = 1'b0;
    fall_nx    = 1'b0;
    emit       = 1'b0;
    unique case (state)
      S_OFF: begin
        if (din) begin
          state_nx   = S_ON;
          len_cnt_nx = LEN_ONE;
          sat_nx     = (LEN_ONE == LEN_MAX);
          rise_nx    = 1'b1;
        end
      end
      S_ON: begin
        if (din) begin
          // Counter parks at max; sat stays set until the interval ends.
          if (len_cnt != LEN_MAX) begin
            len_cnt_nx = len_cnt + 1'b1;
            sat_nx     = sat | (len_cnt_nx == LEN_MAX);
          end else begin
            sat_nx     = 1'b1;
          end
        end else begin
          state_nx   = S_OFF;
          len_cnt_nx = '0;
          sat_nx     = 1'b0;
          fall_nx    = 1'b1;
          emit       = 1'b1;
        end
      end
      default: begin
        state_nx = S_OFF;
      end
    endcase
  end

  assign on_state = (state == S_ON);

  onoff_len_outreg #(
    .CNT_W  (CNT_W),
    .DROP_W (DROP_W)
  ) u_outreg (
    .clk       (clk),
    .reset     (reset),
    .emit      (emit),
    .emit_len  (len_cnt),
    .emit_sat  (sat),
    .len_valid (len_valid),
    .len_ready (len_ready),
    .len_data  (len_data),
    .len_sat   (len_sat),
    .drop_cnt  (drop_cnt)
  );

endmodule

// File: tb/tb_onoff_dwell_tracker.sv
// Scoreboard bench for onoff_dwell_tracker: run-length reference model
// feeding expectation queues, checked by an independent monitor.
module tb_onoff_dwell_tracker;

  localparam int CW   = 4;
  localparam int DW   = 3;
  localparam int MAX  = (1 << CW) - 1;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk;
  logic          reset;
  logic          din;
  logic          rise;
  logic          fall;
  logic          on_state;
  logic          len_valid;
  logic          len_ready;
  logic [CW-1:0] len_data;
  logic          len_sat;
  logic [DW-1:0] drop_cnt;

  onoff_dwell_tracker #(
    .CNT_W  (CW),
    .DROP_W (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .rise      (rise),
    .fall      (fall),
    .on_state  (on_state),
    .len_valid (len_valid),
    .len_ready (len_ready),
    .len_data  (len_data),
    .len_sat   (len_sat),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rise;
    bit fall;
    bit on;
    bit valid;
    bit sat;
    int len;
    int drops;
  } exp_t;

  typedef struct {
    int len;
    bit sat;
  } rec_t;

  exp_t expq[$];
  rec_t recq[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: interval length as a plain run count.
  bit m_on    = 0;
  int m_run   = 0;
  bit m_full  = 0;
  int m_len   = 0;
  bit m_sat   = 0;
  int m_drops = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  task automatic step(input bit r, input bit d, input bit rdy);
    exp_t e;
    rec_t rc;
    bit   fire;
    bit   emit;
    reset     = r;
    din       = d;
    len_ready = rdy;
    e.rise = 0;
    e.fall = 0;
    if (r) begin
      m_on = 0; m_run = 0; m_full = 0;
      m_len = 0; m_sat = 0; m_drops = 0;
    end else begin
      fire   = m_full && rdy;
      emit   = m_on && !d;
      e.rise = !m_on && d;
      e.fall = emit;
      if (emit) begin
        rc.len = (m_run < MAX) ? m_run : MAX;
        rc.sat = (m_run >= MAX);
        if (!m_full || fire) begin
          m_full = 1;
          m_len  = rc.len;
          m_sat  = rc.sat;
          recq.push_back(rc);
        end else if (m_drops < DMAX) begin
          m_drops++;
        end
      end else if (fire) begin
        m_full = 0;
      end
      if (d) begin
        m_run = m_on ? m_run + 1 : 1;
        m_on  = 1;
      end else begin
        m_on  = 0;
        m_run = 0;
      end
    end
    e.on    = m_on;
    e.valid = m_full;
    e.len   = m_len;
    e.sat   = m_sat;
    e.drops = m_drops;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 1, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, rdy);
  endtask

  always @(negedge clk) begin
    exp_t e;
    rec_t r;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("rise",      int'(rise),      int'(e.rise));
      check("fall",      int'(fall),      int'(e.fall));
      check("on_state",  int'(on_state),  int'(e.on));
      check("len_valid", int'(len_valid), int'(e.valid));
      check("len_data",  int'(len_data),  e.len);
      check("len_sat",   int'(len_sat),   int'(e.sat));
      check("drop_cnt",  int'(drop_cnt),  e.drops);
      if (len_valid && len_ready) begin
        if (recq.size() == 0) begin
          check("rec_unexpected", 1, 0);
        end else begin
          r = recq.pop_front();
          check("rec_len", int'(len_data), r.len);
          check("rec_sat", int'(len_sat),  int'(r.sat));
        end
      end
    end
  end

  initial begin
    int  left;
    bit  cur;
    bit  rdy;
    reset = 1; din = 0; len_ready = 1;
    step(1, 0, 1);
    step(1, 0, 1);
    idle(2, 1);
    pulse(3, 1);
    idle(4, 1);
    pulse(1, 1);
    idle(3, 1);
    pulse(20, 1);
    idle(2, 1);
    pulse(2, 1);
    idle(3, 1);
    pulse(4, 0);
    idle(2, 0);
    pulse(6, 0);
    idle(3, 0);
    idle(3, 1);
    pulse(3, 0);
    idle(2, 0);
    pulse(7, 0);
    step(0, 0, 1);
    idle(3, 1);
    pulse(5, 1);
    step(1, 0, 1);
    idle(3, 1);
    pulse(5, 1);
    step(1, 1, 1);
    pulse(2, 1);
    idle(3, 1);
    for (int k = 0; k < 12; k++) begin
      pulse(2, 0);
      idle(1, 0);
    end
    idle(2, 1);
    cur  = 0;
    left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        cur  = ~cur;
        left = ($urandom_range(0, 3) == 0) ?
               $urandom_range(1, 25) : $urandom_range(1, 5);
      end
      left--;
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) step(1, cur, rdy);
      else step(0, cur, rdy);
    end
    idle(6, 1);
    @(negedge clk);
    @(negedge clk);
    check("rec_queue_drained", recq.size(), 0);
    check("exp_queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
